// File: rtl/mcu_bus_pkg.sv
// Purpose: shared types, constants and decode math for the MCU data-bus interconnect.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mcu_bus_pkg;

    // Transfer phases of the interconnect.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        ERR    = 2'd3
    } bus_state_t;

    // Read data returned with every error response.
    localparam logic [31:0] BUS_ERR_RDATA = 32'hDEAD_BEEF;

    // Window index for a base-relative byte offset.
    function automatic logic [63:0] slave_idx(input logic [63:0] off, input int unsigned winAw);
        return off >> winAw;
    endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// Purpose: maps a byte address onto one of NUM_SLAVES equal windows above BASE_ADDR.
// Latency: combinational.
// Backpressure: none; pure function of addr.
module bus_addr_decoder
    import mcu_bus_pkg::*;
#(
    parameter int                NUM_SLAVES = 4,
    parameter int                ADDR_W     = 32,
    parameter int                WIN_AW     = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h1000_0000,
    parameter int                IDX_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [IDX_W-1:0]  idx,
    output logic              hit
);

    logic [ADDR_W-1:0] off;
    logic [63:0]       idxFull;

    // Subtraction wraps for addresses below the base; the >= test rejects those.
    assign off     = addr - BASE_ADDR;
    assign idxFull = slave_idx(64'(off), WIN_AW);
    assign hit     = (addr >= BASE_ADDR) && (idxFull < 64'(NUM_SLAVES));
    assign idx     = idxFull[IDX_W-1:0];

endmodule

// File: rtl/mcu_bus_interconnect.sv
// Purpose: single-master to NUM_SLAVES data-bus bridge with decode, wait states, error and timeout.
// Latency: m_ready 2 cycles after m_req for a zero-wait slave (+1 per wait), 1 for unmapped, TIMEOUT+1 on timeout.
// Backpressure: slave stalls via s_ready; m_req is only sampled in IDLE, so the master waits for m_ready.
module mcu_bus_interconnect
    import mcu_bus_pkg::*;
#(
    parameter int                NUM_SLAVES = 4,
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter int                WIN_AW     = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h1000_0000,
    parameter int                TIMEOUT    = 15
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         m_req,
    input  logic                         m_we,
    input  logic [ADDR_W-1:0]            m_addr,
    input  logic [DATA_W-1:0]            m_wdata,
    input  logic [DATA_W/8-1:0]          m_wstrb,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         m_ready,
    output logic                         m_err,
    output logic [NUM_SLAVES-1:0]        s_sel,
    output logic                         s_we,
    output logic [WIN_AW-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    output logic [DATA_W/8-1:0]          s_wstrb,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]        s_ready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    bus_state_t          state, stateNext;
    logic [CNT_W-1:0]    cnt, cntNext;
    logic [IDX_W-1:0]    idxReg, idxNext;
    logic [DATA_W-1:0]   capData, capNext;
    logic [NUM_SLAVES-1:0] selNext;
    logic                weNext;
    logic [WIN_AW-1:0]   addrNext;
    logic [DATA_W-1:0]   wdataNext;
    logic [STRB_W-1:0]   wstrbNext;

    logic [IDX_W-1:0]    decIdx;
    logic                decHit;
    logic                slvReady;
    logic [DATA_W-1:0]   selRdata;

    bus_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .WIN_AW     (WIN_AW),
        .BASE_ADDR  (BASE_ADDR),
        .IDX_W      (IDX_W)
    ) u_dec (
        .addr (m_addr),
        .idx  (decIdx),
        .hit  (decHit)
    );

    // Only the selected slave's ready counts; s_sel is zero outside ACCESS.
    assign slvReady = |(s_ready & s_sel);
    assign selRdata = s_rdata[idxReg*DATA_W +: DATA_W];

    // Next-state, request latching, timeout counting and master-side response decode.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        idxNext   = idxReg;
        capNext   = capData;
        selNext   = s_sel;
        weNext    = s_we;
        addrNext  = s_addr;
        wdataNext = s_wdata;
        wstrbNext = s_wstrb;
        m_ready   = 1'b0;
        m_err     = 1'b0;
        m_rdata   = '0;
        case (state)
            IDLE: begin
                if (m_req) begin
                    weNext    = m_we;
                    addrNext  = m_addr[WIN_AW-1:0];
                    wdataNext = m_wdata;
                    wstrbNext = m_we ? m_wstrb : '0;
                    idxNext   = decIdx;
                    cntNext   = '0;
                    if (decHit) begin
                        stateNext = ACCESS;
                        selNext   = NUM_SLAVES'(1) << decIdx;
                    end else begin
                        stateNext = ERR;
                    end
                end
            end
            ACCESS: begin
                // Ready is checked first so a reply in the last allowed cycle still succeeds.
                if (slvReady) begin
                    capNext   = s_we ? '0 : selRdata;
                    selNext   = '0;
                    stateNext = RESP;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    selNext   = '0;
                    stateNext = ERR;
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            RESP: begin
                m_ready   = 1'b1;
                m_rdata   = capData;
                stateNext = IDLE;
            end
            ERR: begin
                m_ready   = 1'b1;
                m_err     = 1'b1;
                m_rdata   = DATA_W'(BUS_ERR_RDATA);
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // State and slave-side registers; reset abandons any transfer without a response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idxReg  <= '0;
            capData <= '0;
            s_sel   <= '0;
            s_we    <= 1'b0;
            s_addr  <= '0;
            s_wdata <= '0;
            s_wstrb <= '0;
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            idxReg  <= idxNext;
            capData <= capNext;
            s_sel   <= selNext;
            s_we    <= weNext;
            s_addr  <= addrNext;
            s_wdata <= wdataNext;
            s_wstrb <= wstrbNext;
        end
    end

endmodule
